// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit words, writes them to instr_mem and releases the core when loaded
module imem_loader #(
  parameter int          NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_ldr_i,
  input  logic [15:0] len_ldr_i,
  input  logic        byte_valid_ldr_i,
  input  logic [7:0]  byte_data_ldr_i,
  output logic        byte_ready_ldr_o,
  output logic        wr_en_imem_ldr_o,
  output logic [31:0] addr_imem_ldr_o,
  output logic [31:0] wr_instr_imem_ldr_o,
  output logic        cpu_reset_ldr_o,
  output logic        busy_ldr_o,
  output logic        done_ldr_o,
  output logic        err_ldr_o
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
  state_t      state, state_nxt;
  logic [1:0]  byte_idx, lane;
  logic [15:0] word_idx, len_q;
  logic [31:0] buf_q, buf_nxt, addr_q, instr_q;
  logic        wr_q, take, last_byte, last_word;
  assign take      = byte_valid_ldr_i && state == LOAD;
  assign last_byte = byte_idx == 2'd3;
  assign last_word = word_idx == len_q - 16'd1;
  assign lane      = BIG_ENDIAN ? ~byte_idx : byte_idx;
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state: start decides the path from IDLE, final byte ends LOAD
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start_ldr_i)
      state_nxt = len_ldr_i == 16'd0 ? DONE : int'(len_ldr_i) > NUM_WORDS ? ERR : LOAD;
    else if (take && last_byte && last_word)
      state_nxt = DONE;
  end
  // outputs: core stays in reset until the cycle after the final write pulse
  always_comb begin
    byte_ready_ldr_o    = state == LOAD;
    busy_ldr_o          = state == LOAD;
    done_ldr_o          = state == DONE;
    err_ldr_o           = state == ERR;
    cpu_reset_ldr_o     = !(state == DONE && !wr_q);
    wr_en_imem_ldr_o    = wr_q && !reset;
    addr_imem_ldr_o     = addr_q;
    wr_instr_imem_ldr_o = instr_q;
  end
  // drop the incoming byte into its lane of the word being assembled
  always_comb begin
    buf_nxt = buf_q;
    buf_nxt[{lane, 3'b000} +: 8] = byte_data_ldr_i;
  end
  // datapath: byte/word counters and the write registers
  always_ff @(posedge clk)
    if (reset) begin
      byte_idx <= 2'd0;
      word_idx <= 16'd0;
      len_q    <= 16'd0;
      buf_q    <= 32'd0;
      addr_q   <= 32'd0;
      instr_q  <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      wr_q <= take && last_byte;
      if (state == IDLE && start_ldr_i) begin
        len_q    <= len_ldr_i;
        word_idx <= 16'd0;
        byte_idx <= 2'd0;
      end
      if (take) begin
        buf_q    <= buf_nxt;
        byte_idx <= byte_idx + 2'd1;
      end
      if (take && last_byte) begin
        addr_q   <= BASE_ADDR + {14'd0, word_idx, 2'b00};
        instr_q  <= buf_nxt;
        word_idx <= word_idx + 16'd1;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives two loader configurations with one byte stream and checks writes against a word-list model
module tb_imem_loader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, valid = 1'b0;
  logic [15:0] len = 16'd0;
  logic [7:0]  data = 8'd0;
  logic        rdy [2], wen [2], cres [2], busy [2], done [2], err [2];
  logic [31:0] addr [2], instr [2];
  logic [63:0] q0 [$], q1 [$];
  logic [7:0]  bytes [$];
  int          compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  imem_loader u0 (
    .clk(clk), .reset(reset), .start_ldr_i(start), .len_ldr_i(len),
    .byte_valid_ldr_i(valid), .byte_data_ldr_i(data), .byte_ready_ldr_o(rdy[0]),
    .wr_en_imem_ldr_o(wen[0]), .addr_imem_ldr_o(addr[0]), .wr_instr_imem_ldr_o(instr[0]),
    .cpu_reset_ldr_o(cres[0]), .busy_ldr_o(busy[0]), .done_ldr_o(done[0]), .err_ldr_o(err[0])
  );
  imem_loader #(.BIG_ENDIAN(1'b0), .BASE_ADDR(32'h400)) u1 (
    .clk(clk), .reset(reset), .start_ldr_i(start), .len_ldr_i(len),
    .byte_valid_ldr_i(valid), .byte_data_ldr_i(data), .byte_ready_ldr_o(rdy[1]),
    .wr_en_imem_ldr_o(wen[1]), .addr_imem_ldr_o(addr[1]), .wr_instr_imem_ldr_o(instr[1]),
    .cpu_reset_ldr_o(cres[1]), .busy_ldr_o(busy[1]), .done_ldr_o(done[1]), .err_ldr_o(err[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pack(input int k, input int w);
    logic [7:0] b0, b1, b2, b3;
    b0 = bytes[4*w]; b1 = bytes[4*w+1]; b2 = bytes[4*w+2]; b3 = bytes[4*w+3];
    return k == 0 ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction
  task automatic expect_words(input int n);
    for (int w = 0; w < n; w++) begin
      q0.push_back({32'h0 + 32'(4*w), pack(0, w)});
      q1.push_back({32'h400 + 32'(4*w), pack(1, w)});
    end
  endtask
  task automatic mon();
    logic [63:0] e;
    for (int k = 0; k < 2; k++)
      if (wen[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_wr", {31'd0, wen[k]}, 32'd0);
        else begin
          e = k == 0 ? q0.pop_front() : q1.pop_front();
          chk("wr_addr", addr[k], e[63:32]);
          chk("wr_data", instr[k], e[31:0]);
        end
      end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask
  task automatic do_start(input int l);
    start = 1'b1; len = 16'(l);
    cyc();
    start = 1'b0;
  endtask
  task automatic feed(input int n, input int gap_pct);
    int i = 0, budget = 0;
    logic r;
    while (i < n && budget < 8000) begin
      valid = $urandom_range(99) >= gap_pct;
      data = bytes[i];
      r = rdy[0];
      cyc();
      if (valid && r) i++;
      budget++;
    end
    valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
  endtask
  task automatic new_bytes(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask
  task automatic end_chk();
    for (int k = 0; k < 2; k++) begin
      chk("last_pulse", {31'd0, wen[k]}, 32'd1);
      chk("done_on_pulse", {31'd0, done[k]}, 32'd1);
      chk("cres_on_pulse", {31'd0, cres[k]}, 32'd1);
      chk("rdy_in_done", {31'd0, rdy[k]}, 32'd0);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("cres_released", {31'd0, cres[k]}, 32'd0);
      chk("wen_after", {31'd0, wen[k]}, 32'd0);
      chk("done_sticky", {31'd0, done[k]}, 32'd1);
    end
    chk("missing_wr0", q0.size(), 0);
    chk("missing_wr1", q1.size(), 0);
  endtask
  task automatic load(input int l, input int gap_pct);
    do_reset();
    expect_words(l);
    do_start(l);
    chk("busy_load", {31'd0, busy[0]}, 32'd1);
    feed(4*l, gap_pct);
    end_chk();
  endtask
  initial begin
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdy", {31'd0, rdy[k]}, 32'd0);
      chk("rst_wen", {31'd0, wen[k]}, 32'd0);
      chk("rst_addr", addr[k], 32'd0);
      chk("rst_instr", instr[k], 32'd0);
      chk("rst_cres", {31'd0, cres[k]}, 32'd1);
      chk("rst_busy", {31'd0, busy[k]}, 32'd0);
      chk("rst_done", {31'd0, done[k]}, 32'd0);
      chk("rst_err", {31'd0, err[k]}, 32'd0);
    end
    reset = 1'b0;
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    load(2, 0);
    do_reset();
    valid = 1'b1; data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_rdy", {31'd0, rdy[0]}, 32'd0);
    end
    expect_words(2);
    do_start(2);
    feed(8, 40);
    end_chk();
    do_reset();
    do_start(0);
    chk("len0_done", {31'd0, done[0]}, 32'd1);
    chk("len0_busy", {31'd0, busy[0]}, 32'd0);
    cyc();
    chk("len0_cres", {31'd0, cres[0]}, 32'd0);
    do_start(2);
    chk("start_in_done", {31'd0, busy[0]}, 32'd0);
    do_reset();
    do_start(257);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("err_flag", {31'd0, err[1]}, 32'd1);
      chk("err_rdy", {31'd0, rdy[0]}, 32'd0);
      chk("err_cres", {31'd0, cres[0]}, 32'd1);
      cyc();
    end
    valid = 1'b0;
    do_reset();
    new_bytes(16);
    expect_words(1);
    do_start(4);
    feed(5, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst_cres", {31'd0, cres[0]}, 32'd1);
    cyc();
    chk("midrst_idle", {31'd0, busy[1]}, 32'd0);
    chk("midrst_q", q0.size(), 0);
    new_bytes(4);
    expect_words(1);
    do_start(1);
    feed(4, 30);
    end_chk();
    reset = 1'b1; start = 1'b1; len = 16'd2;
    cyc();
    reset = 1'b0; start = 1'b0;
    cyc();
    chk("rst_wins_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_wins_done", {31'd0, done[0]}, 32'd0);
    bytes = '{8'h05, 8'h00, 8'h08, 8'h20};
    load(1, 0);
    new_bytes(12);
    load(3, 20);
    for (int t = 0; t < 4; t++) begin
      int l = $urandom_range(6, 1);
      new_bytes(4*l);
      load(l, $urandom_range(60));
    end
    new_bytes(1024);
    load(256, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
